// File: rtl/m_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding
// and the default instruction word driven when nothing valid is held.
package m_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage : m_fetch_unit_pkg

// File: rtl/m_fetch_unit.sv
// Single-outstanding-request instruction fetch unit.
// Samples the PC in IDLE, issues one word-aligned memory read, holds the
// returned instruction for decode and tracks flushes that arrive while a
// read is still in flight (DROP waits for the orphaned response).
// Optional feature macro: FETCH_MISALIGN_EXC_EN -- a misaligned PC skips the
// memory read and presents a NOP with fetch_exc raised instead.
module m_fetch_unit
    import m_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_stall_o,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              dec_ready,
    output logic              fetch_exc
);

    // Clears the two byte-offset bits so every read is word aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              exc_q;

    // Fetch FSM: instruction/PC/exception registers only change on state
    // transitions, so they stay stable for the whole HOLD period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
            exc_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!flush) begin
`ifdef FETCH_MISALIGN_EXC_EN
                        if (pc_in[1:0] != 2'b00) begin
                            state_q    <= ST_HOLD;
                            instr_q    <= NOP_INSTR;
                            instr_pc_q <= pc_in;
                            exc_q      <= 1'b1;
                        end else
`endif
                        begin
                            addr_q  <= pc_in & ALIGN_MASK;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q    <= ST_HOLD;
                            instr_q    <= mem_rdata;
                            instr_pc_q <= addr_q;
                            exc_q      <= 1'b0;
                        end
                    end else if (flush) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    // Request stays up until the abandoned response returns.
                    if (mem_ack) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (dec_ready || flush) begin
                        state_q <= ST_IDLE;
                        instr_q <= NOP_INSTR;
                        exc_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode: all outputs except the PC stall come straight from registers.
    always_comb begin
        mem_req     = (state_q == ST_REQ) || (state_q == ST_DROP);
        mem_addr    = addr_q & ALIGN_MASK;
        instr_valid = (state_q == ST_HOLD);
        instr_out   = instr_q;
        instr_pc    = instr_pc_q;
        fetch_exc   = exc_q;
        pc_stall_o  = ((state_q != ST_HOLD) || !dec_ready) && !flush;
    end

endmodule : m_fetch_unit

// File: tb/tb_m_fetch_unit.sv
// Randomized self-checking bench for m_fetch_unit with a transaction-level
// reference model, plus a few directed scenarios with literal expectations.
module tb_m_fetch_unit;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset, flush, mem_ack, dec_ready;
    logic [ADDR_W-1:0] pc_in;
    logic [31:0]       mem_rdata;
    logic              pc_stall_o, mem_req, instr_valid, fetch_exc;
    logic [ADDR_W-1:0] mem_addr, instr_pc;
    logic [31:0]       instr_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m_fetch_unit #(.NOP_INSTR(NOP), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_stall_o (pc_stall_o),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr_valid(instr_valid),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .dec_ready  (dec_ready),
        .fetch_exc  (fetch_exc)
    );

    // Reference model: a read is either in flight (wanted or abandoned) or an
    // instruction is waiting for decode, or the unit is free to take a PC.
    bit                m_inflight;     // read outstanding
    bit                m_abandoned;    // outstanding read whose data must be thrown away
    bit                m_holding;      // instruction waiting for decode
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_instr;
    logic [ADDR_W-1:0] m_pc;
    bit                m_exc;

    always @(posedge clk) begin
        if (reset) begin
            m_inflight <= 0; m_abandoned <= 0; m_holding <= 0;
            m_addr <= '0; m_instr <= NOP; m_pc <= '0; m_exc <= 0;
        end else if (m_holding) begin
            if (dec_ready || flush) begin
                m_holding <= 0; m_instr <= NOP; m_exc <= 0;
            end
        end else if (m_inflight) begin
            if (mem_ack) begin
                m_inflight <= 0; m_abandoned <= 0;
                if (!flush && !m_abandoned) begin
                    m_holding <= 1; m_instr <= mem_rdata; m_pc <= m_addr; m_exc <= 0;
                end
            end else if (flush) begin
                m_abandoned <= 1;
            end
        end else if (!flush) begin
`ifdef FETCH_MISALIGN_EXC_EN
            if (pc_in % 4 != 0) begin
                m_holding <= 1; m_instr <= NOP; m_pc <= pc_in; m_exc <= 1;
            end else begin
                m_inflight <= 1; m_addr <= pc_in;
            end
`else
            m_inflight <= 1; m_addr <= pc_in - (pc_in % 4);
`endif
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then compare every
    // output with the model before the next rising edge.
    task automatic cyc(input bit rst, input bit fl, input logic [ADDR_W-1:0] pc,
                       input bit ack, input logic [31:0] rd, input bit dr);
        @(negedge clk);
        reset = rst; flush = fl; pc_in = pc; mem_ack = ack; mem_rdata = rd; dec_ready = dr;
        #1;
        chk("mem_req", 64'(mem_req), 64'(m_inflight));
        if (m_inflight) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("instr_valid", 64'(instr_valid), 64'(m_holding));
        chk("instr_out", 64'(instr_out), 64'(m_holding ? m_instr : NOP));
        if (m_holding) chk("instr_pc", 64'(instr_pc), 64'(m_pc));
        chk("fetch_exc", 64'(fetch_exc), 64'(m_holding && m_exc));
        chk("pc_stall", 64'(pc_stall_o), 64'((!m_holding || !dr) && !fl));
        $display("cyc t=%0t rst=%0b fl=%0b pc=%0h ack=%0b dr=%0b | req=%0b addr=%0h v=%0b out=%0h ipc=%0h exc=%0b stall=%0b",
                 $time, rst, fl, pc, ack, dr, mem_req, mem_addr, instr_valid, instr_out,
                 instr_pc, fetch_exc, pc_stall_o);
    endtask

    initial begin
        reset = 1; flush = 0; pc_in = '0; mem_ack = 0; mem_rdata = '0; dec_ready = 0;

        // Reset values (reset also beats a simultaneous ack and flush)
        cyc(1, 1, 32'h0, 1, 32'hFFFF_FFFF, 0);
        cyc(1, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_instr_pc", 64'(instr_pc), 64'h0);
        chk("rst_instr_out", 64'(instr_out), 64'(NOP));

        // Basic fetch: ack two cycles into the request, decode ready
        cyc(0, 0, 32'h1000, 0, 32'h0, 1);
        cyc(0, 0, 32'h1000, 0, 32'h0, 1);
        chk("d1_addr", 64'(mem_addr), 64'h1000);
        cyc(0, 0, 32'h1000, 1, 32'hDEAD_BEEF, 1);
        cyc(0, 0, 32'h1004, 0, 32'h0, 1);
        chk("d1_out", 64'(instr_out), 64'hDEAD_BEEF);
        chk("d1_stall", 64'(pc_stall_o), 64'h0);
        cyc(0, 1, 32'h1004, 0, 32'h0, 0);
        chk("d1_valid_after", 64'(instr_valid), 64'h0);

        // Decode back-pressure for five cycles, then flush in REQ with late ack
        cyc(0, 0, 32'h1004, 0, 32'h0, 0);
        cyc(0, 0, 32'h1004, 1, 32'hCAFE_0001, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 32'h1008, 0, 32'h0, 0);
            chk("bp_out", 64'(instr_out), 64'hCAFE_0001);
            chk("bp_stall", 64'(pc_stall_o), 64'h1);
        end
        cyc(0, 0, 32'h2000, 0, 32'h0, 1);
        cyc(0, 0, 32'h3000, 0, 32'h0, 1);
        cyc(0, 1, 32'h2000, 0, 32'h0, 1);
        cyc(0, 0, 32'h2000, 0, 32'h0, 1);
        chk("drop_req", 64'(mem_req), 64'h1);
        cyc(0, 0, 32'h2000, 0, 32'h0, 1);
        cyc(0, 0, 32'h2000, 1, 32'h1234_5678, 1);
        cyc(0, 0, 32'h2000, 0, 32'h0, 1);
        cyc(0, 0, 32'h2000, 0, 32'h0, 1);
        chk("drop_new_addr", 64'(mem_addr), 64'h2000);

        // Flush and ack in the same cycle
        cyc(0, 1, 32'h2000, 1, 32'hBAD0_0000, 1);
        cyc(0, 0, 32'h2000, 0, 32'h0, 1);
        chk("fa_valid", 64'(instr_valid), 64'h0);

        // Reset mid-request, ack a cycle later is ignored
        cyc(0, 0, 32'h3000, 0, 32'h0, 1);
        cyc(1, 0, 32'h3000, 0, 32'h0, 1);
        cyc(0, 1, 32'h3000, 1, 32'hBAD0_0001, 1);
        chk("rr_req", 64'(mem_req), 64'h0);
        cyc(0, 1, 32'h3000, 0, 32'h0, 1);
        chk("rr_valid", 64'(instr_valid), 64'h0);

        // Misaligned PC
        cyc(0, 0, 32'h1002, 0, 32'h0, 0);
`ifdef FETCH_MISALIGN_EXC_EN
        cyc(0, 0, 32'h1002, 0, 32'h0, 0);
        chk("mis_req", 64'(mem_req), 64'h0);
        chk("mis_exc", 64'(fetch_exc), 64'h1);
        chk("mis_pc", 64'(instr_pc), 64'h1002);
`else
        cyc(0, 0, 32'h1002, 0, 32'h0, 0);
        chk("mis_addr", 64'(mem_addr), 64'h1000);
        chk("mis_exc", 64'(fetch_exc), 64'h0);
`endif
        cyc(1, 0, 32'h0, 0, 32'h0, 0);

        // Randomized traffic, including stray acks while idle or holding
        for (int i = 0; i < 3000; i++) begin
            logic [ADDR_W-1:0] pc;
            pc = $urandom;
            if ($urandom_range(5) != 0) pc[1:0] = 2'b00;
            cyc($urandom_range(99) == 0, $urandom_range(7) == 0, pc,
                $urandom_range(2) == 0, $urandom, $urandom_range(1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_m_fetch_unit
